// File: rtl/calendar_date_counter_if.sv
// Signal bundle between the calendar counter and its environment: control pulses,
// load fields, the days_in_month_leap query/answer pair and the registered date.
interface calendar_date_counter_if;
    logic        day_tick;
    logic        load;
    logic [4:0]  load_day;
    logic [3:0]  load_month;
    logic [13:0] load_year;
    logic [5:0]  dim;
    logic [3:0]  dim_month;
    logic        dim_leap;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [13:0] year;
    logic        leap;
    logic        busy;
    logic        load_ok;
    logic        load_err;
    logic        year_wrap;

    modport master (
        output day_tick, load, load_day, load_month, load_year, dim,
        input  dim_month, dim_leap, day, month, year, leap, busy,
               load_ok, load_err, year_wrap
    );

    modport slave (
        input  day_tick, load, load_day, load_month, load_year, dim,
        output dim_month, dim_leap, day, month, year, leap, busy,
               load_ok, load_err, year_wrap
    );
endinterface

// File: rtl/calendar_date_counter.sv
// Day/month/year register advancing one day per tick, with a one-cycle CHECK state
// that validates loaded dates against the external days-in-month lookup.
module calendar_date_counter (
    input  logic                   clk,
    input  logic                   rst_n,
    calendar_date_counter_if.slave bus
);
    typedef enum logic {RUN, CHECK} state_e;

    state_e      state_q, state_d;
    logic [4:0]  day_q, day_d, stg_day_q, stg_day_d;
    logic [3:0]  month_q, month_d, stg_month_q, stg_month_d;
    logic [13:0] year_q, year_d, stg_year_q, stg_year_d;
    logic        pending_q, pending_d;
    logic        busy_q, busy_d;
    logic        load_ok_q, load_ok_d;
    logic        load_err_q, load_err_d;
    logic        year_wrap_q, year_wrap_d;
    logic        leap_cur, leap_stg, load_valid;

    function automatic logic is_leap(input logic [13:0] y);
        return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) ||
               ((y % 14'd400) == 14'd0);
    endfunction

    assign leap_cur = is_leap(year_q);
    assign leap_stg = is_leap(stg_year_q);

    // The lookup answers for the staged date during CHECK, otherwise for the live date.
    assign bus.dim_month = (state_q == CHECK) ? stg_month_q : month_q;
    assign bus.dim_leap  = (state_q == CHECK) ? leap_stg    : leap_cur;

    assign load_valid = (stg_month_q >= 4'd1)  && (stg_month_q <= 4'd12)   &&
                        (stg_year_q  >= 14'd1) && (stg_year_q  <= 14'd9999) &&
                        (stg_day_q   >= 5'd1)  && ({1'b0, stg_day_q} <= bus.dim);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        stg_day_d   = stg_day_q;
        stg_month_d = stg_month_q;
        stg_year_d  = stg_year_q;
        pending_d   = pending_q;
        load_ok_d   = 1'b0;
        load_err_d  = 1'b0;
        year_wrap_d = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.load && !busy_q) begin
                    stg_day_d   = bus.load_day;
                    stg_month_d = bus.load_month;
                    stg_year_d  = bus.load_year;
                    state_d     = CHECK;
                    pending_d   = bus.day_tick;
                end else if (bus.day_tick || pending_q) begin
                    pending_d = pending_q && bus.day_tick;
                    // A dim below 28 means a nonsense month; force a rollover.
                    if (({1'b0, day_q} < bus.dim) && (bus.dim >= 6'd28)) begin
                        day_d = day_q + 5'd1;
                    end else begin
                        day_d = 5'd1;
                        if (month_q == 4'd12) begin
                            month_d = 4'd1;
                            if (year_q == 14'd9999) begin
                                year_d      = 14'd1;
                                year_wrap_d = 1'b1;
                            end else begin
                                year_d = year_q + 14'd1;
                            end
                        end else begin
                            month_d = month_q + 4'd1;
                        end
                    end
                end
            end
            CHECK: begin
                state_d = RUN;
                if (bus.day_tick) pending_d = 1'b1;
                if (load_valid) begin
                    day_d     = stg_day_q;
                    month_d   = stg_month_q;
                    year_d    = stg_year_q;
                    load_ok_d = 1'b1;
                end else begin
                    load_err_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        busy_d = (state_d == CHECK) || pending_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q     <= RUN;
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= 14'd2000;
            stg_day_q   <= 5'd0;
            stg_month_q <= 4'd0;
            stg_year_q  <= 14'd0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            load_ok_q   <= 1'b0;
            load_err_q  <= 1'b0;
            year_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            stg_day_q   <= stg_day_d;
            stg_month_q <= stg_month_d;
            stg_year_q  <= stg_year_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            load_ok_q   <= load_ok_d;
            load_err_q  <= load_err_d;
            year_wrap_q <= year_wrap_d;
        end
    end

    assign bus.day       = day_q;
    assign bus.month     = month_q;
    assign bus.year      = year_q;
    assign bus.leap      = leap_cur;
    assign bus.busy      = busy_q;
    assign bus.load_ok   = load_ok_q;
    assign bus.load_err  = load_err_q;
    assign bus.year_wrap = year_wrap_q;
endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter: a table of load/tick vectors plus
// hand-written sequences for deferred ticks, loads while busy and reset in CHECK.
module tb_calendar_date_counter;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    calendar_date_counter_if bus ();

    calendar_date_counter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for days_in_month_leap.
    always_comb begin
        case (bus.dim_month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: bus.dim = 6'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    bus.dim = 6'd30;
            4'd2:    bus.dim = bus.dim_leap ? 6'd29 : 6'd28;
            default: bus.dim = 6'd0;
        endcase
    end

    typedef struct {
        logic [4:0]  ld_d;
        logic [3:0]  ld_m;
        logic [13:0] ld_y;
        bit          ok;
        int          ticks;
        logic [4:0]  a_d;
        logic [3:0]  a_m;
        logic [13:0] a_y;
        bit          a_leap;
        logic [4:0]  f_d;
        logic [3:0]  f_m;
        logic [13:0] f_y;
        bit          f_leap;
        bit          f_wrap;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_date(input string name, input int d, input int m, input int y, input int lp);
        check({name, ".day"},   int'(bus.day),   d);
        check({name, ".month"}, int'(bus.month), m);
        check({name, ".year"},  int'(bus.year),  y);
        check({name, ".leap"},  int'(bus.leap),  lp);
    endtask

    task automatic check_pulses(input string name, input int ok, input int err, input int wrap);
        check({name, ".load_ok"},   int'(bus.load_ok),   ok);
        check({name, ".load_err"},  int'(bus.load_err),  err);
        check({name, ".year_wrap"}, int'(bus.year_wrap), wrap);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [4:0] d, input logic [3:0] m, input logic [13:0] y);
        bus.load       = 1'b1;
        bus.load_day   = d;
        bus.load_month = m;
        bus.load_year  = y;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", idx);
        drive_load(v.ld_d, v.ld_m, v.ld_y);
        step();
        bus.load = 1'b0;
        check({nm, ".check_busy"}, int'(bus.busy), 1);
        check_pulses({nm, ".check"}, 0, 0, 0);
        step();
        check_pulses({nm, ".result"}, int'(v.ok), int'(!v.ok), 0);
        check_date({nm, ".result"}, v.a_d, v.a_m, v.a_y, v.a_leap);
        check({nm, ".result_busy"}, int'(bus.busy), 0);
        for (int t = 0; t < v.ticks; t++) begin
            bus.day_tick = 1'b1;
            step();
            bus.day_tick = 1'b0;
            check($sformatf("%s.tick%0d_wrap", nm, t), int'(bus.year_wrap),
                  int'(v.f_wrap && (t == v.ticks - 1)));
        end
        if (v.ticks > 0) check_date({nm, ".final"}, v.f_d, v.f_m, v.f_y, v.f_leap);
        step();
        check_pulses({nm, ".idle"}, 0, 0, 0);
    endtask

    initial begin
        //           day    mon    year      ok ticks  after-load               final                          wrap
        vecs[0]  = '{5'd28, 4'd2,  14'd2024,  1, 1, 5'd28, 4'd2, 14'd2024, 1, 5'd29, 4'd2, 14'd2024, 1, 0};
        vecs[1]  = '{5'd28, 4'd2,  14'd2024,  1, 2, 5'd28, 4'd2, 14'd2024, 1, 5'd1,  4'd3, 14'd2024, 1, 0};
        vecs[2]  = '{5'd28, 4'd2,  14'd2023,  1, 1, 5'd28, 4'd2, 14'd2023, 0, 5'd1,  4'd3, 14'd2023, 0, 0};
        vecs[3]  = '{5'd15, 4'd3,  14'd1900,  1, 0, 5'd15, 4'd3, 14'd1900, 0, 5'd15, 4'd3, 14'd1900, 0, 0};
        vecs[4]  = '{5'd10, 4'd6,  14'd2000,  1, 0, 5'd10, 4'd6, 14'd2000, 1, 5'd10, 4'd6, 14'd2000, 1, 0};
        vecs[5]  = '{5'd31, 4'd12, 14'd2024,  1, 1, 5'd31, 4'd12,14'd2024, 1, 5'd1,  4'd1, 14'd2025, 0, 0};
        vecs[6]  = '{5'd31, 4'd12, 14'd9999,  1, 1, 5'd31, 4'd12,14'd9999, 0, 5'd1,  4'd1, 14'd1,    0, 1};
        vecs[7]  = '{5'd15, 4'd4,  14'd2024,  1, 0, 5'd15, 4'd4, 14'd2024, 1, 5'd15, 4'd4, 14'd2024, 1, 0};
        vecs[8]  = '{5'd29, 4'd2,  14'd2023,  0, 0, 5'd15, 4'd4, 14'd2024, 1, 5'd15, 4'd4, 14'd2024, 1, 0};
        vecs[9]  = '{5'd31, 4'd4,  14'd2024,  0, 0, 5'd15, 4'd4, 14'd2024, 1, 5'd15, 4'd4, 14'd2024, 1, 0};
        vecs[10] = '{5'd1,  4'd13, 14'd2024,  0, 0, 5'd15, 4'd4, 14'd2024, 1, 5'd15, 4'd4, 14'd2024, 1, 0};
        vecs[11] = '{5'd1,  4'd1,  14'd0,     0, 0, 5'd15, 4'd4, 14'd2024, 1, 5'd15, 4'd4, 14'd2024, 1, 0};
        vecs[12] = '{5'd1,  4'd1,  14'd10000, 0, 0, 5'd15, 4'd4, 14'd2024, 1, 5'd15, 4'd4, 14'd2024, 1, 0};
        vecs[13] = '{5'd0,  4'd1,  14'd2024,  0, 1, 5'd15, 4'd4, 14'd2024, 1, 5'd16, 4'd4, 14'd2024, 1, 0};

        rst_n          = 1'b0;
        bus.day_tick   = 1'b0;
        bus.load       = 1'b0;
        bus.load_day   = 5'd0;
        bus.load_month = 4'd0;
        bus.load_year  = 14'd0;
        step();
        step();

        check_date("reset", 1, 1, 2000, 1);
        check("reset.dim_month", int'(bus.dim_month), 1);
        check("reset.dim_leap",  int'(bus.dim_leap),  1);
        check("reset.busy",      int'(bus.busy),      0);
        check_pulses("reset", 0, 0, 0);

        rst_n = 1'b1;
        step();
        check_date("idle", 1, 1, 2000, 1);

        bus.day_tick = 1'b1;
        step();
        bus.day_tick = 1'b0;
        check_date("tick1", 2, 1, 2000, 1);
        check_pulses("tick1", 0, 0, 0);

        bus.day_tick = 1'b1;
        for (int i = 0; i < 30; i++) step();
        bus.day_tick = 1'b0;
        check_date("tick31", 1, 2, 2000, 1);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Tick during CHECK is deferred and applied to the committed date.
        drive_load(5'd31, 4'd1, 14'd2024);
        step();
        bus.load = 1'b0;
        check("defer.check_busy",  int'(bus.busy),      1);
        check("defer.dim_month",   int'(bus.dim_month), 1);
        check("defer.dim_leap",    int'(bus.dim_leap),  1);
        bus.day_tick = 1'b1;
        step();
        bus.day_tick = 1'b0;
        check_pulses("defer.result", 1, 0, 0);
        check_date("defer.result", 31, 1, 2024, 1);
        check("defer.pending_busy", int'(bus.busy), 1);
        step();
        check_date("defer.after", 1, 2, 2024, 1);
        check("defer.after_busy", int'(bus.busy), 0);
        check_pulses("defer.after", 0, 0, 0);

        // Load+tick together, then further loads while busy are dropped.
        drive_load(5'd10, 4'd5, 14'd2024);
        bus.day_tick = 1'b1;
        step();
        bus.day_tick = 1'b0;
        check("busyld.check_busy", int'(bus.busy), 1);
        check_date("busyld.check", 1, 2, 2024, 1);
        drive_load(5'd20, 4'd6, 14'd2024);
        step();
        check_pulses("busyld.result", 1, 0, 0);
        check_date("busyld.result", 10, 5, 2024, 1);
        check("busyld.pending_busy", int'(bus.busy), 1);
        drive_load(5'd7, 4'd7, 14'd2024);
        step();
        bus.load = 1'b0;
        check_date("busyld.advance", 11, 5, 2024, 1);
        check_pulses("busyld.advance", 0, 0, 0);
        check("busyld.advance_busy", int'(bus.busy), 0);
        step();
        check_date("busyld.idle", 11, 5, 2024, 1);
        check_pulses("busyld.idle", 0, 0, 0);
        check("busyld.idle_busy", int'(bus.busy), 0);

        // Reset asserted in the CHECK cycle wins over the pending load.
        drive_load(5'd8, 4'd8, 14'd2024);
        step();
        bus.load = 1'b0;
        check("rstchk.check_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        step();
        check_date("rstchk.reset", 1, 1, 2000, 1);
        check_pulses("rstchk.reset", 0, 0, 0);
        check("rstchk.busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        step();
        check_date("rstchk.after", 1, 1, 2000, 1);
        check_pulses("rstchk.after", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
